// File: rtl/conv_out_writer.sv
// conv_out_writer: accumulates the product terms of one output pixel, adds the
// channel bias, rescales, saturates to a signed byte and writes it to output
// memory. Pixels are scanned k (column) fastest, then j (row), then i (channel).
module conv_out_writer #(
    parameter int CONV_DIM_OUT = 32,
    parameter int CONV_OUT_CH  = 32,
    parameter int DATA_W       = 16,
    parameter int ACC_W        = 32,
    parameter int OUT_SHIFT    = 8,
    parameter int RELU         = 1,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              prod_valid,
    input  logic [DATA_W-1:0] prod_data,
    input  logic              win_end,
    output logic              prod_ready,
    output logic [7:0]        bias_ch,
    input  logic [ACC_W-1:0]  bias,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done
);

    // Counter widths stay at least 1 bit so DIM=1 / CH=1 builds still elaborate.
    localparam int K_W = (CONV_DIM_OUT > 1) ? $clog2(CONV_DIM_OUT) : 1;
    localparam int I_W = (CONV_OUT_CH > 1) ? $clog2(CONV_OUT_CH) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(CONV_DIM_OUT - 1);
    localparam logic [I_W-1:0] I_LAST = I_W'(CONV_OUT_CH - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FINAL, S_WRITE, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  scaled;
    logic [7:0]               sat;
    logic [ADDR_W-1:0]        addr_calc;
    logic [K_W-1:0]           k, j;
    logic [I_W-1:0]           i;
    logic                     last_pix;

    assign prod_ready = (state == S_ACCUM);
    assign busy       = (state == S_ACCUM) || (state == S_FINAL) || (state == S_WRITE);
    assign done       = (state == S_DONE);
    assign bias_ch    = 8'(i);
    assign last_pix   = (i == I_LAST) && (j == K_LAST) && (k == K_LAST);

    // Bias add (wrapping), arithmetic rescale, optional ReLU, then byte saturation.
    always_comb begin
        sum    = acc + $signed(bias);
        scaled = sum >>> OUT_SHIFT;
        if (RELU != 0 && scaled < 0)
            scaled = '0;
        if (scaled > SAT_HI)
            sat = 8'h7f;
        else if (scaled < SAT_LO)
            sat = 8'h80;
        else
            sat = scaled[7:0];
    end

    // Linear output address from the channel/row/column counters.
    always_comb begin
        addr_calc = ADDR_W'(i) * ADDR_W'(CONV_DIM_OUT * CONV_DIM_OUT)
                  + ADDR_W'(j) * ADDR_W'(CONV_DIM_OUT)
                  + ADDR_W'(k);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; start only matters when the sweep is not running.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ACCUM;
            S_ACCUM: if (win_end) state_nxt = S_FINAL;
            S_FINAL: state_nxt = S_WRITE;
            S_WRITE: if (wr_ready) state_nxt = last_pix ? S_DONE : S_ACCUM;
            S_DONE:  if (start) state_nxt = S_ACCUM;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Accumulator, pixel counters and the registered write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        acc <= '0;
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                    end
                end
                S_ACCUM: begin
                    // A product arriving with win_end is still part of this pixel.
                    if (prod_valid)
                        acc <= acc + ACC_W'($signed(prod_data));
                end
                S_FINAL: begin
                    wr_data <= sat;
                    wr_addr <= addr_calc;
                    wr_en   <= 1'b1;
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        wr_en <= 1'b0;
                        acc   <= '0;
                        if (last_pix) begin
                            i <= '0;
                            j <= '0;
                            k <= '0;
                        end else if (k == K_LAST) begin
                            k <= '0;
                            if (j == K_LAST) begin
                                j <= '0;
                                i <= i + 1'b1;
                            end else begin
                                j <= j + 1'b1;
                            end
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_out_writer.sv
// Directed bench for conv_out_writer. u0 runs a 2x2x2 sweep with no shift and
// no ReLU; u1/u2 share stimulus and run a 2x2x1 sweep with SHIFT=8, RELU=0/1.
module tb_conv_out_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        start0, pv0, we0, wrr0;
    logic [15:0] pd0;
    logic [31:0] bias0;
    logic        pr0, wen0, busy0, done0;
    logic [7:0]  bch0, wd0;
    logic [15:0] wa0;

    logic        start1, pv1, we1, wrr1;
    logic [15:0] pd1;
    logic [31:0] bias1;
    logic        pr1, wen1, busy1, done1;
    logic        pr2, wen2, busy2, done2;
    logic [7:0]  bch1, wd1, bch2, wd2;
    logic [15:0] wa1, wa2;

    int errors = 0;
    int checks = 0;

    conv_out_writer #(.CONV_DIM_OUT(2), .CONV_OUT_CH(2), .OUT_SHIFT(0), .RELU(0)) u0 (
        .clk(clk), .reset(reset), .start(start0), .prod_valid(pv0), .prod_data(pd0),
        .win_end(we0), .prod_ready(pr0), .bias_ch(bch0), .bias(bias0), .wr_en(wen0),
        .wr_addr(wa0), .wr_data(wd0), .wr_ready(wrr0), .busy(busy0), .done(done0));

    conv_out_writer #(.CONV_DIM_OUT(2), .CONV_OUT_CH(1), .OUT_SHIFT(8), .RELU(0)) u1 (
        .clk(clk), .reset(reset), .start(start1), .prod_valid(pv1), .prod_data(pd1),
        .win_end(we1), .prod_ready(pr1), .bias_ch(bch1), .bias(bias1), .wr_en(wen1),
        .wr_addr(wa1), .wr_data(wd1), .wr_ready(wrr1), .busy(busy1), .done(done1));

    conv_out_writer #(.CONV_DIM_OUT(2), .CONV_OUT_CH(1), .OUT_SHIFT(8), .RELU(1)) u2 (
        .clk(clk), .reset(reset), .start(start1), .prod_valid(pv1), .prod_data(pd1),
        .win_end(we1), .prod_ready(pr2), .bias_ch(bch2), .bias(bias1), .wr_en(wen2),
        .wr_addr(wa2), .wr_data(wd2), .wr_ready(wrr1), .busy(busy2), .done(done2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feeds n terms then win_end; returns with u0 in WRITE (wr_en visible).
    task automatic pix0(input int n, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [31:0] bv);
        bias0 = bv;
        for (int t = 0; t < n; t++) begin
            pv0 = 1'b1;
            pd0 = (t == 0) ? a : (t == 1) ? b : c;
            step();
        end
        pv0 = 1'b0; we0 = 1'b1; step();
        we0 = 1'b0; step();
    endtask

    task automatic hs0();
        wrr0 = 1'b1; step(); wrr0 = 1'b0;
    endtask

    task automatic pix1(input int n, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] bv);
        bias1 = bv;
        for (int t = 0; t < n; t++) begin
            pv1 = 1'b1;
            pd1 = (t == 0) ? a : b;
            step();
        end
        pv1 = 1'b0; we1 = 1'b1; step();
        we1 = 1'b0; step();
    endtask

    task automatic hs1();
        wrr1 = 1'b1; step(); wrr1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        checks++; if (wen0 !== 1'b0)   begin errors++; $display("FAIL reset_wr_en: got %b want 0", wen0); end
        checks++; if (wa0 !== 16'd0)   begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wa0); end
        checks++; if (wd0 !== 8'd0)    begin errors++; $display("FAIL reset_wr_data: got %0d want 0", wd0); end
        checks++; if (pr0 !== 1'b0)    begin errors++; $display("FAIL reset_prod_ready: got %b want 0", pr0); end
        checks++; if (busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done0); end
        checks++; if (bch0 !== 8'd0)   begin errors++; $display("FAIL reset_bias_ch: got %0d want 0", bch0); end
        checks++; if (wen1 !== 1'b0 || wd2 !== 8'd0) begin errors++; $display("FAIL reset_u1u2: got wen=%b data=%0d want 0/0", wen1, wd2); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        start0 = 1'b1; step(); start0 = 1'b0;
        checks++; if (pr0 !== 1'b1 || busy0 !== 1'b1) begin errors++; $display("FAIL basic_accum_flags: got ready=%b busy=%b want 1/1", pr0, busy0); end
        bias0 = 32'd5;
        pv0 = 1'b1; pd0 = 16'd10; step();
        pd0 = 16'd20; step();
        pd0 = 16'd30; step();
        pv0 = 1'b0; we0 = 1'b1; step(); we0 = 1'b0;
        checks++; if (wen0 !== 1'b0 || pr0 !== 1'b0) begin errors++; $display("FAIL basic_final_cycle: got wr_en=%b ready=%b want 0/0", wen0, pr0); end
        step();
        checks++; if (wen0 !== 1'b1) begin errors++; $display("FAIL basic_wr_en: got %b want 1", wen0); end
        checks++; if (wd0 !== 8'd65) begin errors++; $display("FAIL basic_data: got %0d want 65", wd0); end
        checks++; if (wa0 !== 16'd0) begin errors++; $display("FAIL basic_addr: got %0d want 0", wa0); end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 3; c++) begin
            pv0 = 1'b1; pd0 = 16'd1000; we0 = 1'b1;
            step();
            checks++; if (wen0 !== 1'b1 || wd0 !== 8'd65 || wa0 !== 16'd0 || pr0 !== 1'b0)
                begin errors++; $display("FAIL stall_hold%0d: got en=%b data=%0d addr=%0d ready=%b want 1/65/0/0", c, wen0, wd0, wa0, pr0); end
        end
        pv0 = 1'b0; we0 = 1'b0;
        hs0();
        checks++; if (wen0 !== 1'b0 || pr0 !== 1'b1) begin errors++; $display("FAIL stall_release: got en=%b ready=%b want 0/1", wen0, pr0); end
    endtask

    task automatic test_empty_window();
        pix0(0, 16'd0, 16'd0, 16'd0, 32'hFFFF_FED4); // bias -300
        checks++; if (wd0 !== 8'h80)  begin errors++; $display("FAIL empty_data: got %0d want -128", $signed(wd0)); end
        checks++; if (wa0 !== 16'd1)  begin errors++; $display("FAIL empty_addr: got %0d want 1", wa0); end
        hs0();
    endtask

    task automatic test_same_cycle();
        bias0 = 32'd5;
        pv0 = 1'b1; pd0 = 16'd7; we0 = 1'b1; step();
        pv0 = 1'b0; we0 = 1'b0; step();
        checks++; if (wd0 !== 8'd12 || wa0 !== 16'd2) begin errors++; $display("FAIL same_cycle: got data=%0d addr=%0d want 12/2", wd0, wa0); end
        hs0();
    endtask

    task automatic test_start_ignored();
        bias0 = 32'd0;
        start0 = 1'b1; pv0 = 1'b1; pd0 = 16'hFFCE; step(); // -50
        start0 = 1'b0; pd0 = 16'hFFC4; step();              // -60
        pv0 = 1'b0; we0 = 1'b1; step();
        we0 = 1'b0; step();
        checks++; if (wd0 !== 8'h92 || wa0 !== 16'd3) begin errors++; $display("FAIL start_ignored: got data=%0d addr=%0d want -110/3", $signed(wd0), wa0); end
        hs0();
    endtask

    task automatic test_sweep();
        for (int p = 4; p < 8; p++) begin
            checks++; if (bch0 !== 8'd1) begin errors++; $display("FAIL sweep_bias_ch%0d: got %0d want 1", p, bch0); end
            pix0(1, 16'(p * 3), 16'd0, 16'd0, 32'd0);
            checks++; if (wa0 !== 16'(p) || wd0 !== 8'(p * 3)) begin errors++; $display("FAIL sweep_px%0d: got addr=%0d data=%0d want %0d/%0d", p, wa0, wd0, p, p * 3); end
            hs0();
            if (p < 7) begin
                checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL sweep_early_done%0d: got %b want 0", p, done0); end
            end
        end
        checks++; if (done0 !== 1'b1 || busy0 !== 1'b0 || wen0 !== 1'b0 || bch0 !== 8'd0)
            begin errors++; $display("FAIL sweep_done: got done=%b busy=%b en=%b ch=%0d want 1/0/0/0", done0, busy0, wen0, bch0); end
    endtask

    task automatic test_saturate();
        start1 = 1'b1; step(); start1 = 1'b0;
        pix1(0, 16'd0, 16'd0, 32'd100000);
        checks++; if (wd1 !== 8'd127 || wd2 !== 8'd127 || wa1 !== 16'd0) begin errors++; $display("FAIL sat_pos: got %0d/%0d addr=%0d want 127/127/0", wd1, wd2, wa1); end
        hs1();
        pix1(0, 16'd0, 16'd0, 32'hFFFE_7960); // -100000
        checks++; if (wd1 !== 8'h80) begin errors++; $display("FAIL sat_neg_norelu: got %0d want -128", $signed(wd1)); end
        checks++; if (wd2 !== 8'd0)  begin errors++; $display("FAIL sat_neg_relu: got %0d want 0", $signed(wd2)); end
        hs1();
        pix1(0, 16'd0, 16'd0, 32'hFFFF_FF38); // -200 >>> 8 = -1
        checks++; if (wd1 !== 8'hFF || wd2 !== 8'd0 || wa1 !== 16'd2) begin errors++; $display("FAIL shift_small_neg: got %0d/%0d addr=%0d want -1/0/2", $signed(wd1), wd2, wa1); end
        hs1();
        pix1(2, 16'd256, 16'd512, 32'd25000); // 25768 >>> 8 = 100
        checks++; if (wd1 !== 8'd100 || wd2 !== 8'd100 || wa2 !== 16'd3) begin errors++; $display("FAIL shift_mid: got %0d/%0d addr=%0d want 100/100/3", wd1, wd2, wa2); end
        hs1();
        checks++; if (done1 !== 1'b1 || done2 !== 1'b1) begin errors++; $display("FAIL sat_done: got %b/%b want 1/1", done1, done2); end
    endtask

    task automatic test_reset_abort();
        start0 = 1'b1; step(); start0 = 1'b0;
        for (int p = 0; p < 3; p++) begin
            pix0(1, 16'd5, 16'd0, 16'd0, 32'd0);
            hs0();
        end
        pv0 = 1'b1; pd0 = 16'd500; step(); step();
        pv0 = 1'b0;
        reset = 1'b0; #1;
        checks++; if (wen0 !== 1'b0 || wa0 !== 16'd0 || wd0 !== 8'd0 || pr0 !== 1'b0 ||
                      busy0 !== 1'b0 || done0 !== 1'b0 || bch0 !== 8'd0)
            begin errors++; $display("FAIL abort_outputs: got en=%b addr=%0d data=%0d rdy=%b busy=%b done=%b ch=%0d want all 0",
                                     wen0, wa0, wd0, pr0, busy0, done0, bch0); end
        step();
        reset = 1'b1; step();
        start0 = 1'b1; step(); start0 = 1'b0;
        pix0(0, 16'd0, 16'd0, 16'd0, 32'd9);
        checks++; if (wd0 !== 8'd9 || wa0 !== 16'd0) begin errors++; $display("FAIL abort_restart: got data=%0d addr=%0d want 9/0", wd0, wa0); end
        hs0();
    endtask

    initial begin
        reset = 1'b0;
        start0 = 1'b0; pv0 = 1'b0; we0 = 1'b0; wrr0 = 1'b0; pd0 = '0; bias0 = '0;
        start1 = 1'b0; pv1 = 1'b0; we1 = 1'b0; wrr1 = 1'b0; pd1 = '0; bias1 = '0;
        test_reset();
        test_basic();
        test_stall();
        test_empty_window();
        test_same_cycle();
        test_start_ignored();
        test_sweep();
        test_saturate();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
